// File: rtl/pwm_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// pwm_cmd_ctrl : ASCII line-command parser driving PWM frequency/duty registers
// Optional macro PWM_CMD_ACK_EN adds a one-byte 'K'/'E' response channel.
// Revision: 1.0
// ============================================================================
module pwm_cmd_ctrl #(
  parameter int MIN_FREQ_HZ     = 1,
  parameter int MAX_FREQ_HZ     = 100_000,
  parameter int DEFAULT_FREQ_HZ = 1_000,
  parameter int DEFAULT_DUTY    = 50,
  parameter int MAX_DIGITS      = 6
) (
  input  logic        clk_50mhz,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        buffer_full,
  output logic [19:0] freq_hz,
  output logic [6:0]  duty_pct,
  output logic        cfg_update,
  output logic        cmd_error,
  output logic        busy
`ifdef PWM_CMD_ACK_EN
  ,
  output logic [7:0]  ack_data,
  output logic        ack_valid,
  input  logic        ack_ready
`endif
);

  localparam int          CNT_W     = $clog2(MAX_DIGITS + 2);
  localparam logic [19:0] MIN_F     = 20'(MIN_FREQ_HZ);
  localparam logic [19:0] MAX_F     = 20'(MAX_FREQ_HZ);
  localparam logic [19:0] DEF_F     = 20'(DEFAULT_FREQ_HZ);
  localparam logic [6:0]  DEF_D     = 7'(DEFAULT_DUTY);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARG   = 2'd1,
    S_EXEC  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           state, state_n;
  logic             op_freq, op_freq_n;
  logic [19:0]      acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ovf, ovf_n;
  logic [19:0]      freq_n;
  logic [6:0]       duty_n;
  logic             upd_n, err_n;

  logic        is_term, is_f, is_d, is_digit, arg_ok;
  logic [23:0] mac;

  assign is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign is_f     = (rx_data == 8'h46) || (rx_data == 8'h66);
  assign is_d     = (rx_data == 8'h44) || (rx_data == 8'h64);
  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign mac      = ({4'd0, acc} * 24'd10) + {20'd0, rx_data[3:0]};

  always_comb begin
    arg_ok = (cnt != '0) && !ovf;
    if (op_freq) arg_ok = arg_ok && (acc >= MIN_F) && (acc <= MAX_F);
    else         arg_ok = arg_ok && (acc <= 20'd100);
  end

  always_comb begin
    state_n   = state;
    op_freq_n = op_freq;
    acc_n     = acc;
    cnt_n     = cnt;
    ovf_n     = ovf;
    freq_n    = freq_hz;
    duty_n    = duty_pct;
    upd_n     = 1'b0;
    err_n     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_valid && !is_term) begin
          if (is_f || is_d) begin
            op_freq_n = is_f;
            acc_n     = '0;
            cnt_n     = '0;
            ovf_n     = 1'b0;
            state_n   = S_ARG;
          end else begin
            err_n   = 1'b1;
            state_n = S_DRAIN;
          end
        end
      end
      S_ARG: begin
        if (buffer_full) begin
          err_n   = 1'b1;
          state_n = S_DRAIN;
        end else if (rx_valid) begin
          if (is_digit) begin
            if (cnt == MAX_CNT) begin
              err_n   = 1'b1;
              state_n = S_DRAIN;
            end else begin
              acc_n = mac[19:0];
              cnt_n = cnt + 1'b1;
              ovf_n = ovf | (|mac[23:20]);
            end
          end else if (is_term) begin
            state_n = S_EXEC;
          end else begin
            err_n   = 1'b1;
            state_n = S_DRAIN;
          end
        end
      end
      S_EXEC: begin
        // The terminator has already been consumed, so an overflow abort here
        // returns straight to IDLE instead of draining the next line.
        state_n = S_IDLE;
        if (buffer_full || !arg_ok) begin
          err_n = 1'b1;
        end else begin
          upd_n = 1'b1;
          if (op_freq) freq_n = acc;
          else         duty_n = acc[6:0];
        end
      end
      S_DRAIN: begin
        if (rx_valid && is_term) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_freq    <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      freq_hz    <= DEF_F;
      duty_pct   <= DEF_D;
      cfg_update <= 1'b0;
      cmd_error  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      op_freq    <= op_freq_n;
      acc        <= acc_n;
      cnt        <= cnt_n;
      ovf        <= ovf_n;
      freq_hz    <= freq_n;
      duty_pct   <= duty_n;
      cfg_update <= upd_n;
      cmd_error  <= err_n;
      busy       <= (state_n != S_IDLE);
    end
  end

`ifdef PWM_CMD_ACK_EN
  // A fresh result overwrites any response still waiting for ack_ready.
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      ack_valid <= 1'b0;
      ack_data  <= 8'h00;
    end else if (upd_n || err_n) begin
      ack_valid <= 1'b1;
      ack_data  <= err_n ? 8'h45 : 8'h4B;
    end else if (ack_valid && ack_ready) begin
      ack_valid <= 1'b0;
    end
  end
`endif

endmodule
`default_nettype wire
